// File: rtl/iob_ram_t2p_fifo_ctrl.sv
// iob_ram_t2p_fifo_ctrl
// Synchronous FIFO controller driving an external two-port RAM with a
// registered (1-cycle) read port. The controller generates the RAM write and
// read strobes and addresses, and passes the RAM read data straight out.
//
// Optional feature: define IOB_RAM_T2P_FIFO_CTRL_THRESH_EN to add the
// registered almost_full_o / almost_empty_o threshold flags.
//
// Handshake: a push is accepted in any cycle where w_en_i=1, w_full_o=0 and
// cke_i=1. A pop is accepted in any cycle where r_en_i=1, r_empty_o=0 and
// cke_i=1. Requests that are not accepted are dropped and are not held over.
// A popped word appears on r_data_o one cycle later, qualified by a
// single-cycle r_valid_o pulse.
module iob_ram_t2p_fifo_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_full_o,
  input  logic              r_en_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_valid_o,
  output logic              r_empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
`ifdef IOB_RAM_T2P_FIFO_CTRL_THRESH_EN
  ,
  output logic              almost_full_o,
  output logic              almost_empty_o
`endif
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  // Pointers carry one extra wrap bit; the RAM address is the low ADDR_W bits.
  logic [ADDR_W:0] r_w_ptr;
  logic [ADDR_W:0] r_r_ptr;
  logic [ADDR_W:0] r_level;
  logic            r_full;
  logic            r_empty;
  logic            r_valid;

  logic            w_push;
  logic            w_pop;
  logic [ADDR_W:0] w_level_nxt;

  assign w_push = w_en_i & ~r_full  & cke_i;
  assign w_pop  = r_en_i & ~r_empty & cke_i;

  assign ext_mem_w_en_o   = w_push;
  assign ext_mem_w_addr_o = r_w_ptr[ADDR_W-1:0];
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = w_pop;
  assign ext_mem_r_addr_o = r_r_ptr[ADDR_W-1:0];

  // No bypass: read data comes only from the RAM's registered port.
  assign r_data_o  = ext_mem_r_data_i;
  assign r_valid_o = r_valid;
  assign w_full_o  = r_full;
  assign r_empty_o = r_empty;
  assign level_o   = r_level;

  // Next occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + ONE;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - ONE;
    end
  end

  // Pointer, occupancy, status flag and read-valid registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_valid <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        r_w_ptr <= '0;
        r_r_ptr <= '0;
        r_level <= '0;
        r_full  <= 1'b0;
        r_empty <= 1'b1;
        r_valid <= 1'b0;
      end else begin
        if (w_push) begin
          r_w_ptr <= r_w_ptr + ONE;
        end
        if (w_pop) begin
          r_r_ptr <= r_r_ptr + ONE;
        end
        r_level <= w_level_nxt;
        r_full  <= (w_level_nxt == DEPTH);
        r_empty <= (w_level_nxt == '0);
        r_valid <= w_pop;
      end
    end
  end

`ifdef IOB_RAM_T2P_FIFO_CTRL_THRESH_EN
  localparam logic [ADDR_W:0] AFULL_THR  = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] AEMPTY_THR = (ADDR_W+1)'(AEMPTY_LVL);

  logic r_afull;
  logic r_aempty;

  assign almost_full_o  = r_afull;
  assign almost_empty_o = r_aempty;

  // Threshold flags track the same next-level value as the full/empty flags.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else if (cke_i) begin
      if (rst_i) begin
        r_afull  <= 1'b0;
        r_aempty <= 1'b1;
      end else begin
        r_afull  <= (w_level_nxt >= AFULL_THR);
        r_aempty <= (w_level_nxt <= AEMPTY_THR);
      end
    end
  end
`endif

endmodule

// File: tb/tb_iob_ram_t2p_fifo_ctrl.sv
// Testbench for iob_ram_t2p_fifo_ctrl (DATA_W=8, ADDR_W=4) with a small
// registered-read two-port RAM attached to the ext_mem_* ports.
module tb_iob_ram_t2p_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cke = 1'b1;
  logic          rst = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_en = 1'b0;
  logic          w_full, r_valid, r_empty;
  logic [DW-1:0] r_data;
  logic [AW:0]   level;
  logic          m_w_en, m_r_en;
  logic [AW-1:0] m_w_addr, m_r_addr;
  logic [DW-1:0] m_w_data, m_r_data;
`ifdef IOB_RAM_T2P_FIFO_CTRL_THRESH_EN
  logic afull, aempty;
`endif

  iob_ram_t2p_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AFULL_LVL(12), .AEMPTY_LVL(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .rst_i(rst),
    .w_en_i(w_en), .w_data_i(w_data), .w_full_o(w_full),
    .r_en_i(r_en), .r_data_o(r_data), .r_valid_o(r_valid), .r_empty_o(r_empty),
    .level_o(level),
    .ext_mem_w_en_o(m_w_en), .ext_mem_w_addr_o(m_w_addr), .ext_mem_w_data_o(m_w_data),
    .ext_mem_r_en_o(m_r_en), .ext_mem_r_addr_o(m_r_addr), .ext_mem_r_data_i(m_r_data)
`ifdef IOB_RAM_T2P_FIFO_CTRL_THRESH_EN
    , .almost_full_o(afull), .almost_empty_o(aempty)
`endif
  );

  // ---------------- attached two-port RAM ----------------
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (m_w_en) mem[m_w_addr] <= m_w_data;
    if (m_r_en) m_r_data <= mem[m_r_addr];
  end

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_data = '0;
  int            wr_cnt = 0;
  int            rd_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue; accepted words are counted to give RAM addresses.
  initial begin
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n || (cke && rst)) begin
        exp_q.delete();
        exp_valid = 1'b0;
        wr_cnt = 0;
        rd_cnt = 0;
      end else if (cke) begin
        bit push_ok, pop_ok;
        push_ok = w_en && (exp_q.size() < DEPTH);
        pop_ok  = r_en && (exp_q.size() > 0);
        exp_valid = pop_ok;
        if (pop_ok) begin
          exp_data = exp_q.pop_front();
          rd_cnt++;
        end
        if (push_ok) begin
          exp_q.push_back(w_data);
          wr_cnt++;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int sz;
        bit e_wen, e_ren;
        sz = exp_q.size();
        e_wen = w_en && cke && (sz < DEPTH);
        e_ren = r_en && cke && (sz > 0);
        chk("level", int'(level), sz);
        chk("full", int'(w_full), int'(sz == DEPTH));
        chk("empty", int'(r_empty), int'(sz == 0));
        chk("r_valid", int'(r_valid), int'(exp_valid));
        if (exp_valid) chk("r_data", int'(r_data), int'(exp_data));
        chk("mem_w_en", int'(m_w_en), int'(e_wen));
        if (e_wen) begin
          chk("mem_w_addr", int'(m_w_addr), wr_cnt % DEPTH);
          chk("mem_w_data", int'(m_w_data), int'(w_data));
        end
        chk("mem_r_en", int'(m_r_en), int'(e_ren));
        if (e_ren) chk("mem_r_addr", int'(m_r_addr), rd_cnt % DEPTH);
`ifdef IOB_RAM_T2P_FIFO_CTRL_THRESH_EN
        chk("almost_full", int'(afull), int'(sz >= 12));
        chk("almost_empty", int'(aempty), int'(sz <= 4));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re);
    w_en = we; w_data = wd; r_en = re;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    // 1. reset and idle
    idle(2);
    arst_n = 1'b1;
    idle(3);
    chk("lit_reset_level", int'(level), 0);
    chk("lit_reset_empty", int'(r_empty), 1);

    // 2. fill with 32..47, then one dropped push of 99
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(32 + i), 1'b0);
    chk("lit_full_flag", int'(w_full), 1);
    chk("lit_full_level", int'(level), 16);
    cyc(1'b1, 8'd99, 1'b0);
    chk("lit_drop_level", int'(level), 16);

    // 3. drain 16, then a 17th pop on empty
    cyc(1'b0, '0, 1'b1);
    chk("lit_first_pop", int'(r_data), 32);
    for (int i = 1; i < 16; i++) cyc(1'b0, '0, 1'b1);
    chk("lit_last_pop", int'(r_data), 47);
    cyc(1'b0, '0, 1'b1);
    idle(1);
    chk("lit_empty_again", int'(r_empty), 1);

    // 4. fill to 8, then 40 cycles of push+pop across the address wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(100 + i), 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(150 + i), 1'b1);
    chk("lit_steady_level", int'(level), 8);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    idle(2);

    // clock enable low: state holds, strobes suppressed
    cke = 1'b0;
    cyc(1'b1, 8'h3C, 1'b1);
    cyc(1'b1, 8'h3D, 1'b1);
    cke = 1'b1;
    idle(1);

    // 5. push+pop when empty, then when full
    cyc(1'b1, 8'h11, 1'b1);
    chk("lit_pp_empty_level", int'(level), 1);
    chk("lit_pp_empty_valid", int'(r_valid), 0);
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'(i + 1), 1'b0);
    cyc(1'b1, 8'h77, 1'b1);
    chk("lit_pp_full_level", int'(level), 15);
    chk("lit_pp_full_data", int'(r_data), 8'h11);
    idle(1);

    // 6a. async reset at level 5 mid-stream
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1);
    chk("lit_level5", int'(level), 5);
    w_en = 1'b1; w_data = 8'h55; r_en = 1'b1;
    #2 arst_n = 1'b0;
    #1;
    chk("lit_arst_level", int'(level), 0);
    chk("lit_arst_empty", int'(r_empty), 1);
    w_en = 1'b0; r_en = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("lit_arst_a5", int'(r_data), 8'hA5);

    // 6b. soft reset at level 9, with a push in the same cycle
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(60 + i), 1'b0);
    chk("lit_level9", int'(level), 9);
    rst = 1'b1;
    cyc(1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    chk("lit_srst_level", int'(level), 0);
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("lit_srst_a5", int'(r_data), 8'hA5);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
